cic_comb_decimator: RTL and testbench
=====================================

Name: cic_comb_decimator

Overview:
- Decimating comb section of the CIC decimation filter. It is the back end that pairs with the integrator chain.
- Accepts the integrator-chain output stream (Data_i / DataNd_i) and keeps every DecimRate-th accepted sample.
- Runs the kept samples through NumStages pipelined comb (differentiator) stages.
- Emits one decimated, filtered sample per DecimRate accepted inputs, with a single-cycle valid strobe.

Parameters:
- DataWidth, 18, width of data path in/out. Equals integrator output width; no growth or truncation.
- DecimRate, 8, decimation factor R; legal 1..1024.
- NumStages, 3, number of comb stages N; legal 1..8.
- DiffDelay, 1, differential delay M in decimated samples; legal 1 or 2.

Ports:
- Clk_i  in  1  clock; all logic rises on posedge.
- Rst_i  in  1  synchronous active-high reset.
- Data_i  in  DataWidth  two's-complement sample from the integrator chain.
- DataNd_i  in  1  new-data strobe; Data_i sampled when high.
- Data_o  out  DataWidth  two's-complement decimated comb output.
- DataValid_o  out  1  one-cycle strobe; Data_o valid while high.

Behaviour:
- Interface: one clock (Clk_i); reset Rst_i is synchronous and active-high.
- Reset:
  - Decimation counter = 0.
  - All comb delay registers, stage registers, and Data_o = 0.
  - DataValid_o = 0.
  - Reset overrides every other input in the same cycle.
- Decimation counter:
  - Counts 0..DecimRate-1.
  - Advances only on edges where DataNd_i = 1.
  - Wraps DecimRate-1 -> 0.
  - DataNd_i = 0 holds the counter and all state.
- Decimation capture:
  - Occurs when DataNd_i = 1 and counter = DecimRate-1.
  - Data_i is loaded into the stage-0 register and a stage-0 valid bit is set for one cycle.
  - DecimRate = 1: every accepted sample is captured.
- Comb stage k (1..N):
  - Updates only on the cycle after stage k-1 valid.
  - y_k = x_k - x_k delayed by M, where x_k = y_(k-1).
  - The delay line is M registers per stage, shifted only on that stage's valid event.
  - Stage valid propagates one cycle per stage.
- Latency:
  - Capture at edge e -> DataValid_o = 1 for exactly one cycle following edge e+NumStages.
  - Data_o is registered and holds its value between strobes.
  - DataValid_o never stays high two consecutive cycles unless DecimRate = 1 with DataNd_i continuously high.
- Arithmetic:
  - All subtractions are DataWidth-bit modulo 2^DataWidth (wrap, no saturation). This is required for CIC correctness.
- Start-up: delay lines start at 0, so the first N*M outputs are the transient (first output equals first captured sample).
- Throughput: DataNd_i may be high every cycle; there are no stalls and no back-pressure.
- Reset mid-operation: in-flight pipeline samples are discarded and no DataValid_o is emitted for them. The first post-reset output follows the DecimRate-th accepted post-reset sample.

Optional Feature:
- Macro: CIC_COMB_PHASE_SYNC_EN.
- Defined: adds input port Sync_i (1 bit).
  - Sync_i = 1 forces the decimation counter to phase 0 for the current cycle's evaluation.
  - If DataNd_i = 1 in the same cycle, that sample is index 0: counter -> 1, or capture if DecimRate = 1.
  - If DataNd_i = 0, counter -> 0.
  - Delay lines and pipeline are not cleared; in-flight outputs still emerge.
  - Rst_i has priority over Sync_i.
- Not defined: no Sync_i port. Phase is set only by reset.

Test Plan:
- Reset: assert Rst_i 3 cycles with DataNd_i = 1, Data_i = 0x12345 -> Data_o = 0, DataValid_o = 0 throughout and the cycle after release.
- Ramp (W=18, R=8, N=3, M=1), DataNd_i continuously high, Data_i = 0,1,2,...:
  - Captures are 7,15,23,31,39.
  - Outputs in order: 0x00007, 0x3FFFA (-6), 0x3FFFF (-1), 0x00000, 0x00000.
  - Each strobe lands 3 edges after its capture edge.
- Gapped input: same ramp with DataNd_i high every other cycle -> identical output values, DataValid_o spaced 16 cycles apart. Data_i changes on low-strobe cycles are ignored.
- Wrap (R=1, N=1, M=1): inputs 0x1FFFF, 0x20000 -> outputs 0x1FFFF, then 0x00001 (modulo wrap, no saturation).
- Reset mid-run: continuous ramp, pulse Rst_i after 5 accepted samples -> no stale strobe. Next DataValid_o follows the 8th post-reset accepted sample, with delay lines restarted at zero (first output equals capture).
- With CIC_COMB_PHASE_SYNC_EN: R=8, Sync_i pulsed together with the 3rd accepted sample -> that sample is index 0. The capture occurs 7 accepted samples later, not at the original phase.

Source files
------------

// File: rtl/cic_comb_decimator.sv
// rtl/cic_comb_decimator.sv - CIC decimator back end: keeps every DecimRate-th sample, then NumStages comb stages
// Optional Sync_i phase realignment port is enabled by defining CIC_COMB_PHASE_SYNC_EN.
module cic_comb_decimator #(
  parameter int DataWidth = 18,
  parameter int DecimRate = 8,
  parameter int NumStages = 3,
  parameter int DiffDelay = 1
) (
  input  logic                 Clk_i,
  input  logic                 Rst_i,
`ifdef CIC_COMB_PHASE_SYNC_EN
  input  logic                 Sync_i,
`endif
  input  logic [DataWidth-1:0] Data_i,
  input  logic                 DataNd_i,
  output logic [DataWidth-1:0] Data_o,
  output logic                 DataValid_o
);

  localparam int CntWidth = (DecimRate > 1) ? $clog2(DecimRate) : 1;
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(DecimRate - 1);

  logic [CntWidth-1:0]  cnt;
  logic [CntWidth-1:0]  cnt_eff;
  logic                 capture;
  logic [DataWidth-1:0] stage_data [NumStages+1];
  logic [NumStages:0]   stage_valid;
  logic [DataWidth-1:0] dly [NumStages][DiffDelay];

  // A sync pulse makes the current sample index 0 without touching the comb pipeline.
`ifdef CIC_COMB_PHASE_SYNC_EN
  assign cnt_eff = Sync_i ? '0 : cnt;
`else
  assign cnt_eff = cnt;
`endif

  assign capture = DataNd_i && (cnt_eff == CntLast);

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      cnt         <= '0;
      stage_valid <= '0;
      for (int k = 0; k <= NumStages; k++) begin
        stage_data[k] <= '0;
      end
      for (int k = 0; k < NumStages; k++) begin
        for (int j = 0; j < DiffDelay; j++) begin
          dly[k][j] <= '0;
        end
      end
    end else begin
      if (DataNd_i) begin
        cnt <= capture ? '0 : cnt_eff + 1'b1;
      end else begin
        cnt <= cnt_eff;
      end

      stage_valid[0] <= capture;
      if (capture) begin
        stage_data[0] <= Data_i;
      end

      // Subtraction wraps modulo 2^DataWidth, which the CIC response relies on.
      for (int k = 1; k <= NumStages; k++) begin
        stage_valid[k] <= stage_valid[k-1];
        if (stage_valid[k-1]) begin
          stage_data[k] <= stage_data[k-1] - dly[k-1][DiffDelay-1];
          dly[k-1][0]   <= stage_data[k-1];
          for (int j = 1; j < DiffDelay; j++) begin
            dly[k-1][j] <= dly[k-1][j-1];
          end
        end
      end
    end
  end

  assign Data_o      = stage_data[NumStages];
  assign DataValid_o = stage_valid[NumStages];

endmodule

// File: tb/tb_cic_comb_decimator.sv
// tb/tb_cic_comb_decimator.sv - randomized and directed check of cic_comb_decimator against an arithmetic reference
// Three instances: (R8,N3,M1), (R1,N1,M1), (R3,N2,M2); Sync_i exercised when CIC_COMB_PHASE_SYNC_EN is defined.
module tb_cic_comb_decimator;
  localparam int W  = 18;
  localparam int ND = 3;
`ifdef CIC_COMB_PHASE_SYNC_EN
  localparam bit SyncOn = 1'b1;
`else
  localparam bit SyncOn = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         sync;
  logic         nd   [ND];
  logic [W-1:0] din  [ND];
  logic [W-1:0] dout [ND];
  logic         vld  [ND];

  int total = 0;
  int bad   = 0;
  int edge_n = 0;

  typedef struct {
    int           id;
    int           due;
    logic [W-1:0] val;
  } pend_t;

  pend_t        pend [$];
  int           cnt_m  [ND];
  int           hcount [ND];
  logic [W-1:0] hist   [ND][32];
  logic [W-1:0] last_m [ND];
  logic [W-1:0] out0 [$];
  logic [W-1:0] out1 [$];
  logic [W-1:0] ramp_exp [5];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cic_comb_decimator #(.DataWidth(W), .DecimRate(8), .NumStages(3), .DiffDelay(1)) u0 (
    .Clk_i(clk), .Rst_i(rst),
`ifdef CIC_COMB_PHASE_SYNC_EN
    .Sync_i(sync),
`endif
    .Data_i(din[0]), .DataNd_i(nd[0]), .Data_o(dout[0]), .DataValid_o(vld[0]));

  cic_comb_decimator #(.DataWidth(W), .DecimRate(1), .NumStages(1), .DiffDelay(1)) u1 (
    .Clk_i(clk), .Rst_i(rst),
`ifdef CIC_COMB_PHASE_SYNC_EN
    .Sync_i(sync),
`endif
    .Data_i(din[1]), .DataNd_i(nd[1]), .Data_o(dout[1]), .DataValid_o(vld[1]));

  cic_comb_decimator #(.DataWidth(W), .DecimRate(3), .NumStages(2), .DiffDelay(2)) u2 (
    .Clk_i(clk), .Rst_i(rst),
`ifdef CIC_COMB_PHASE_SYNC_EN
    .Sync_i(sync),
`endif
    .Data_i(din[2]), .DataNd_i(nd[2]), .Data_o(dout[2]), .DataValid_o(vld[2]));

  function automatic int r_of(int id);
    case (id)
      0:       return 8;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  function automatic int n_of(int id);
    case (id)
      0:       return 3;
      1:       return 1;
      default: return 2;
    endcase
  endfunction

  function automatic int m_of(int id);
    return (id == 2) ? 2 : 1;
  endfunction

  function automatic longint binom(int n, int k);
    longint c = 1;
    for (int i = 0; i < k; i++) c = c * (n - i) / (i + 1);
    return c;
  endfunction

  // N-th order M-lag difference of the decimated sequence, zero before the first capture.
  function automatic logic [W-1:0] comb_ref(int id);
    longint acc = 0;
    int n = n_of(id);
    int m = m_of(id);
    for (int j = 0; j <= n; j++) begin
      int idx = hcount[id] - 1 - j * m;
      longint x = (idx >= 0) ? longint'(hist[id][idx % 32]) : 0;
      if (j % 2 == 1) acc = acc - binom(n, j) * x;
      else            acc = acc + binom(n, j) * x;
    end
    return acc[W-1:0];
  endfunction

  task automatic chk(input string tag, input int id, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, id, obs, exp);
    end
  endtask

  task automatic step();
    logic         exp_v;
    logic [W-1:0] exp_d;
    @(posedge clk);
    edge_n++;
    for (int i = 0; i < ND; i++) begin
      if (rst) begin
        cnt_m[i]  = 0;
        hcount[i] = 0;
        last_m[i] = '0;
      end else begin
        if (sync && SyncOn) cnt_m[i] = 0;
        if (nd[i]) begin
          cnt_m[i]++;
          if (cnt_m[i] == r_of(i)) begin
            cnt_m[i] = 0;
            hist[i][hcount[i] % 32] = din[i];
            hcount[i]++;
            pend.push_back('{i, edge_n + n_of(i), comb_ref(i)});
          end
        end
      end
    end
    if (rst) pend.delete();
    #1;
    for (int i = 0; i < ND; i++) begin
      exp_v = 1'b0;
      exp_d = last_m[i];
      for (int k = 0; k < pend.size(); k++) begin
        if (pend[k].id == i && pend[k].due == edge_n) begin
          exp_v     = 1'b1;
          exp_d     = pend[k].val;
          last_m[i] = exp_d;
          pend.delete(k);
          break;
        end
      end
      chk("valid", i, {{(W-1){1'b0}}, vld[i]}, {{(W-1){1'b0}}, exp_v});
      chk("data", i, dout[i], exp_d);
    end
    if (vld[0]) out0.push_back(dout[0]);
    if (vld[1]) out1.push_back(dout[1]);
  endtask

  task automatic idle_all();
    for (int i = 0; i < ND; i++) begin
      nd[i]  = 1'b0;
      din[i] = W'($urandom);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_all();
    step();
    rst = 1'b0;
  endtask

  task automatic chk_out0(input string tag, input int k, input logic [W-1:0] exp);
    logic [W-1:0] obs;
    obs = (k < out0.size()) ? out0[k] : 'x;
    chk(tag, 0, obs, exp);
  endtask

  initial begin
    ramp_exp[0] = 18'h00007;
    ramp_exp[1] = 18'h3FFFA;
    ramp_exp[2] = 18'h3FFFF;
    ramp_exp[3] = 18'h00000;
    ramp_exp[4] = 18'h00000;
    for (int i = 0; i < ND; i++) begin
      cnt_m[i] = 0; hcount[i] = 0; last_m[i] = '0;
    end
    sync = 1'b0;

    // reset held with live strobes and data
    rst = 1'b1;
    for (int i = 0; i < ND; i++) begin
      nd[i] = 1'b1; din[i] = 18'h12345;
    end
    repeat (3) step();
    rst = 1'b0;
    idle_all();
    step();

    // continuous ramp; dut1 sees the modulo-wrap pair
    out0.delete(); out1.delete();
    for (int s = 0; s < 40; s++) begin
      nd[0] = 1'b1; din[0] = W'(s);
      nd[1] = (s < 2); din[1] = (s == 0) ? 18'h1FFFF : (s == 1) ? 18'h20000 : W'($urandom);
      nd[2] = 1'b1; din[2] = W'($urandom);
      step();
    end
    idle_all();
    repeat (6) step();
    for (int k = 0; k < 5; k++) chk_out0("ramp_value", k, ramp_exp[k]);
    chk("wrap_first", 1, (out1.size() > 0) ? out1[0] : 'x, 18'h1FFFF);
    chk("wrap_second", 1, (out1.size() > 1) ? out1[1] : 'x, 18'h00001);

    // gapped ramp, data changes on low-strobe cycles
    do_reset();
    out0.delete();
    for (int c = 0; c < 80; c++) begin
      nd[0] = (c % 2 == 0);
      din[0] = (c % 2 == 0) ? W'(c / 2) : W'($urandom);
      nd[1] = 1'b0; din[1] = W'($urandom);
      nd[2] = (c % 2 == 1); din[2] = W'($urandom);
      step();
    end
    idle_all();
    repeat (6) step();
    for (int k = 0; k < 5; k++) chk_out0("gap_value", k, ramp_exp[k]);

    // reset after 5 accepted samples, then resume the ramp
    do_reset();
    for (int s = 0; s < 5; s++) begin
      nd[0] = 1'b1; din[0] = W'(s);
      step();
    end
    rst = 1'b1; din[0] = W'($urandom);
    step();
    rst = 1'b0;
    out0.delete();
    for (int s = 5; s < 25; s++) begin
      nd[0] = 1'b1; din[0] = W'(s);
      step();
    end
    idle_all();
    repeat (6) step();
    chk_out0("post_reset_first", 0, 18'd12);

`ifdef CIC_COMB_PHASE_SYNC_EN
    // sync on the 3rd accepted sample makes it index 0
    do_reset();
    out0.delete();
    for (int s = 0; s < 20; s++) begin
      nd[0] = 1'b1; din[0] = W'(100 + s);
      sync = (s == 2);
      step();
    end
    sync = 1'b0;
    idle_all();
    repeat (6) step();
    chk_out0("sync_first", 0, 18'd109);
`endif

    // random traffic with occasional reset and sync
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      rst  = ($urandom_range(0, 199) == 0);
      sync = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < ND; i++) begin
        nd[i]  = ($urandom_range(0, 3) != 0);
        din[i] = W'($urandom);
      end
      step();
    end
    rst = 1'b0; sync = 1'b0;
    idle_all();
    repeat (6) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
